// File: rtl/wb_regfile.sv
// Write-back register file: GPR array with a hard-wired zero register, HI/LO pair,
// same-cycle write-to-read bypass and a debug count of committed GPR writes.
module wb_regfile #(
   parameter int REG_NUM   = 32,
   parameter int REG_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(REG_NUM)-1:0] wb_wd,
   input  logic                       wb_wreg,
   input  logic [REG_WIDTH-1:0]       wb_wdata,
   input  logic                       wb_whilo,
   input  logic [REG_WIDTH-1:0]       wb_hi,
   input  logic [REG_WIDTH-1:0]       wb_lo,
   input  logic                       re1,
   input  logic [$clog2(REG_NUM)-1:0] raddr1,
   input  logic                       re2,
   input  logic [$clog2(REG_NUM)-1:0] raddr2,
   output logic [REG_WIDTH-1:0]       rdata1,
   output logic [REG_WIDTH-1:0]       rdata2,
   output logic [REG_WIDTH-1:0]       hi_o,
   output logic [REG_WIDTH-1:0]       lo_o,
   output logic [31:0]                wb_cnt
);

   localparam int AW = $clog2(REG_NUM);

   logic [REG_WIDTH-1:0] gpr [REG_NUM];
   logic [REG_WIDTH-1:0] hi_q;
   logic [REG_WIDTH-1:0] lo_q;
   logic                 gpr_commit;

   assign gpr_commit = wb_wreg && (wb_wd != '0);

   // NOTE: the whole array is reset so that a mid-run reset discards every
   // register; this rules out RAM inference, which is acceptable at this size.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) gpr[i] <= '0;
      end else if (gpr_commit) begin
         // NOTE: non-blocking so every reader sees the pre-edge value.
         gpr[wb_wd] <= wb_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (wb_whilo) begin
         hi_q <= wb_hi;
         lo_q <= wb_lo;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            wb_cnt <= '0;
      else if (gpr_commit) wb_cnt <= wb_cnt + 32'd1;
   end

   // Read port 1: reset and disabled/zero address dominate the bypass.
   always_comb begin
      rdata1 = '0;
      if (rst && re1 && (raddr1 != '0)) begin
         if (wb_wreg && (wb_wd == raddr1)) rdata1 = wb_wdata;
         else                              rdata1 = gpr[raddr1];
      end
   end

   always_comb begin
      rdata2 = '0;
      if (rst && re2 && (raddr2 != '0)) begin
         if (wb_wreg && (wb_wd == raddr2)) rdata2 = wb_wdata;
         else                              rdata2 = gpr[raddr2];
      end
   end

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (rst) begin
         hi_o = wb_whilo ? wb_hi : hi_q;
         lo_o = wb_whilo ? wb_lo : lo_q;
      end
   end

   logic [AW-1:0] unused_aw;
   assign unused_aw = '0;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of general-purpose registers (power of two).
REQ-002 SHALL have parameter REG_WIDTH, default 32, data width of every register.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port wb_wd  input  log2(REG_NUM)  write-back destination register address.
REQ-006 SHALL have port wb_wreg  input  1  write-back GPR write enable, active-high.
REQ-007 SHALL have port wb_wdata  input  REG_WIDTH  write-back GPR data.
REQ-008 SHALL have port wb_whilo  input  1  write-back HI/LO write enable, active-high.
REQ-009 SHALL have port wb_hi  input  REG_WIDTH  write-back HI data.
REQ-010 SHALL have port wb_lo  input  REG_WIDTH  write-back LO data.
REQ-011 SHALL have ports re1/re2  input  1  read-port 1/2 enable, active-high.
REQ-012 SHALL have ports raddr1/raddr2  input  log2(REG_NUM)  read-port 1/2 address.
REQ-013 SHALL have ports rdata1/rdata2  output  REG_WIDTH  read-port 1/2 data, combinational.
REQ-014 SHALL have ports hi_o/lo_o  output  REG_WIDTH  current HI/LO value, bypassed.
REQ-015 SHALL have port wb_cnt  output  32  count of committed GPR writes (debug).

Function
REQ-016 SHALL write wb_wdata into GPR[wb_wd] on a rising clk edge when rst high, wb_wreg=1 and wb_wd!=0.
REQ-017 SHALL ignore writes to address 0; GPR[0] SHALL always read as zero.
REQ-018 SHALL write wb_hi/wb_lo into HI/LO on a rising clk edge when rst high and wb_whilo=1; both updated together.
REQ-019 SHALL drive rdataN = 0 when reN=0, or when raddrN=0.
REQ-020 SHALL drive rdataN = wb_wdata (same-cycle bypass) when reN=1, raddrN!=0, wb_wreg=1 and wb_wd=raddrN.
REQ-021 SHALL otherwise drive rdataN = GPR[raddrN] when reN=1.
REQ-022 SHALL drive hi_o/lo_o = wb_hi/wb_lo when wb_whilo=1, else the stored HI/LO.
REQ-023 SHALL resolve both read ports independently; both addressing the write target SHALL both see bypassed data.
REQ-024 SHALL increment wb_cnt by 1 on each rising edge where a GPR write commits per REQ-016; writes to address 0 SHALL NOT count.
REQ-025 SHALL wrap wb_cnt from 0xFFFFFFFF to 0 without flag.
REQ-026 SHALL treat wb_wreg=0 with any wb_wd/wb_wdata (NOP bubble, wd=0) as no state change.
REQ-027 SHALL have zero-cycle read latency and one-cycle write latency (visible in storage on the edge after presentation, visible on read ports the same cycle via bypass).

Reset
REQ-028 SHALL, while rst=0, asynchronously clear all GPRs, HI, LO and wb_cnt to 0, independent of clk.
REQ-029 SHALL force rdata1/rdata2/hi_o/lo_o to 0 while rst=0, with no bypass.
REQ-030 SHALL block any write whose edge coincides with rst=0; first write accepted on first rising edge with rst=1.
REQ-031 SHALL, on reset assertion mid-operation, discard all prior contents and wb_cnt.

Verification
REQ-032 Reset: rst=0 pulse between edges -> all outputs 0 immediately; read any address after release -> 0, wb_cnt=0.
REQ-033 Write/read: write 0x12345678 to r5, next cycle re1=1 raddr1=5 -> rdata1=0x12345678, wb_cnt=1.
REQ-034 Bypass: wb_wreg=1 wb_wd=7 wb_wdata=0xA5A5A5A5, same cycle raddr1=raddr2=7 re1=re2=1 -> both rdata=0xA5A5A5A5 before the edge.
REQ-035 Zero register: write 0xFFFFFFFF to r0 -> rdata for raddr=0 stays 0, wb_cnt unchanged; re1=0 with raddr1=5 -> rdata1=0.
REQ-036 HI/LO: wb_whilo=1 wb_hi=0x1 wb_lo=0x2 -> hi_o/lo_o=1/2 same cycle and held after wb_whilo=0; wb_whilo=0 with new data -> unchanged.
REQ-037 Counter wrap: 2^32 committed writes (or forced preload) -> wb_cnt wraps 0xFFFFFFFF -> 0.
